// File: rtl/frame_renderer_pkg.sv
// Shared playfield geometry, colours and frame-sequencer encoding for the renderer.
package frame_renderer_pkg;

    localparam logic [10:0] WALL_L_X0  = 11'd200;
    localparam logic [10:0] WALL_L_X1  = 11'd207;
    localparam logic [10:0] WALL_R_X0  = 11'd592;
    localparam logic [10:0] WALL_R_X1  = 11'd599;
    localparam logic [10:0] CEIL_Y0    = 11'd56;
    localparam logic [10:0] CEIL_Y1    = 11'd63;

    localparam logic [10:0] GRID_X0    = 11'd208;
    localparam logic [10:0] GRID_Y0    = 11'd64;
    localparam logic [10:0] BLOCK_W    = 11'd32;
    localparam logic [10:0] BLOCK_H    = 11'd16;
    localparam int          GRID_COLS  = 12;
    localparam int          GRID_ROWS  = 6;
    localparam logic [10:0] GRID_X_END = GRID_X0 + BLOCK_W * 11'(GRID_COLS);
    localparam logic [10:0] GRID_Y_END = GRID_Y0 + BLOCK_H * 11'(GRID_ROWS);

    localparam logic [10:0] PADDLE_Y0  = 11'd560;
    localparam logic [10:0] PADDLE_Y1  = 11'd567;
    localparam logic [10:0] PADDLE_W   = 11'd60;
    localparam logic [10:0] BALL_SIZE  = 11'd10;

    localparam logic [7:0] COLOUR_BALL   = 8'hFF;
    localparam logic [7:0] COLOUR_PADDLE = 8'h1F;
    localparam logic [7:0] COLOUR_RED    = 8'hE0;
    localparam logic [7:0] COLOUR_YELLOW = 8'hFC;
    localparam logic [7:0] COLOUR_GREEN  = 8'h1C;
    localparam logic [7:0] COLOUR_WALL   = 8'h92;
    localparam logic [7:0] COLOUR_BG     = 8'h00;

    localparam logic [9:0]  PADDLE_X_RESET = 10'd370;
    localparam logic [9:0]  BALL_X_RESET   = 10'd395;
    localparam logic [9:0]  BALL_Y_RESET   = 10'd400;
    localparam logic [71:0] BLOCKS_RESET   = 72'hFFF_555_AAA_555_AAA_FFF;

    typedef enum logic [1:0] {
        SEQ_IDLE        = 2'd0,
        SEQ_WAIT_UPDATE = 2'd1,
        SEQ_LATCH       = 2'd2
    } seqState_t;

    // Rows are coloured in pairs from the top: red, yellow, green.
    function automatic logic [7:0] blockColour(input logic [2:0] row);
        if (row < 3'd2)      return COLOUR_RED;
        else if (row < 3'd4) return COLOUR_YELLOW;
        else                 return COLOUR_GREEN;
    endfunction

endpackage

// File: rtl/frame_renderer_block_grid_lookup.sv
// Maps a pixel coordinate to its block cell (registered) and selects that cell's bit from the map.
module block_grid_lookup
    import frame_renderer_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [10:0] xPos,
    input  logic [10:0] yPos,
    input  logic [71:0] blocks,
    output logic        blockHit,
    output logic [2:0]  blockRow
);

    logic       inGrid;
    logic       inGridQ;
    logic [3:0] colQ;
    logic [2:0] rowQ;
    logic [6:0] bitIdx;

    assign inGrid = (xPos >= GRID_X0) && (xPos < GRID_X_END) &&
                    (yPos >= GRID_Y0) && (yPos < GRID_Y_END);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            inGridQ <= 1'b0;
            colQ    <= 4'd0;
            rowQ    <= 3'd0;
        end else begin
            inGridQ <= inGrid;
            colQ    <= 4'((xPos - GRID_X0) >> 5);
            rowQ    <= 3'((yPos - GRID_Y0) >> 4);
        end
    end

    // Out-of-grid pixels force index 0 so the select never leaves the map.
    assign bitIdx   = inGridQ ? (7'(rowQ) * 7'd12 + 7'(colQ)) : 7'd0;
    assign blockHit = inGridQ && blocks[bitIdx];
    assign blockRow = rowQ;

endmodule

// File: rtl/frame_renderer.sv
// Scene rasteriser: per-frame GameLogic update request, blanking-time snapshot, 2-stage pixel colouring.
//   state        | meaning
//   SEQ_IDLE        | waiting for first blanking line, then pulse START_UPDATE
//   SEQ_WAIT_UPDATE | GameLogic running; wait for last line of the frame
//   SEQ_LATCH       | copy live game state into snapshots (one cycle)
module frame_renderer
    import frame_renderer_pkg::*;
#(
    parameter int H_VISIBLE = 800,
    parameter int V_VISIBLE = 600,
    parameter int V_TOTAL   = 628
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [10:0] HCOUNT,
    input  logic [10:0] VCOUNT,
    input  logic        ACTIVE,
    input  logic [9:0]  PADDLE_X_PIXEL,
    input  logic [9:0]  BALL_X_PIXEL,
    input  logic [9:0]  BALL_Y_PIXEL,
    input  logic [71:0] BLOCK_STATE,
    output logic        START_UPDATE,
    output logic [7:0]  RGB,
    output logic        RGB_VALID
);

    seqState_t   seqState;
    logic [9:0]  paddleSnap;
    logic [9:0]  ballXSnap;
    logic [9:0]  ballYSnap;
    logic [71:0] blocksSnap;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            seqState     <= SEQ_IDLE;
            START_UPDATE <= 1'b0;
            paddleSnap   <= PADDLE_X_RESET;
            ballXSnap    <= BALL_X_RESET;
            ballYSnap    <= BALL_Y_RESET;
            blocksSnap   <= BLOCKS_RESET;
        end else begin
            START_UPDATE <= 1'b0;
            case (seqState)
                SEQ_IDLE: begin
                    if (HCOUNT == 11'd0 && VCOUNT == 11'(V_VISIBLE)) begin
                        START_UPDATE <= 1'b1;
                        seqState     <= SEQ_WAIT_UPDATE;
                    end
                end
                SEQ_WAIT_UPDATE: begin
                    if (HCOUNT == 11'd0 && VCOUNT == 11'(V_TOTAL - 1))
                        seqState <= SEQ_LATCH;
                end
                SEQ_LATCH: begin
                    paddleSnap <= PADDLE_X_PIXEL;
                    ballXSnap  <= BALL_X_PIXEL;
                    ballYSnap  <= BALL_Y_PIXEL;
                    blocksSnap <= BLOCK_STATE;
                    seqState   <= SEQ_IDLE;
                end
                default: seqState <= SEQ_IDLE;
            endcase
        end
    end

    logic [10:0] paddleX;
    logic [10:0] ballX;
    logic [10:0] ballY;
    logic        wallHit;
    logic        paddleHit;
    logic        ballHit;
    logic        actQ;
    logic        drawQ;
    logic        wallQ;
    logic        paddleQ;
    logic        ballQ;
    logic        blockHit;
    logic [2:0]  blockRow;

    assign paddleX = {1'b0, paddleSnap};
    assign ballX   = {1'b0, ballXSnap};
    assign ballY   = {1'b0, ballYSnap};

    // Side walls run from the ceiling down to the bottom of the visible area.
    assign wallHit =
        (VCOUNT >= CEIL_Y0 && VCOUNT <= CEIL_Y1 && HCOUNT >= WALL_L_X0 && HCOUNT <= WALL_R_X1) ||
        (VCOUNT >= CEIL_Y0 && VCOUNT < 11'(V_VISIBLE) &&
         ((HCOUNT >= WALL_L_X0 && HCOUNT <= WALL_L_X1) ||
          (HCOUNT >= WALL_R_X0 && HCOUNT <= WALL_R_X1)));
    assign paddleHit = (VCOUNT >= PADDLE_Y0) && (VCOUNT <= PADDLE_Y1) &&
                       (HCOUNT >= paddleX) && (HCOUNT < paddleX + PADDLE_W);
    assign ballHit   = (HCOUNT >= ballX) && (HCOUNT < ballX + BALL_SIZE) &&
                       (VCOUNT >= ballY) && (VCOUNT < ballY + BALL_SIZE);

    block_grid_lookup uGrid (
        .CLK      (CLK),
        .RESET    (RESET),
        .xPos     (HCOUNT),
        .yPos     (VCOUNT),
        .blocks   (blocksSnap),
        .blockHit (blockHit),
        .blockRow (blockRow)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            actQ    <= 1'b0;
            drawQ   <= 1'b0;
            wallQ   <= 1'b0;
            paddleQ <= 1'b0;
            ballQ   <= 1'b0;
        end else begin
            actQ    <= ACTIVE;
            drawQ   <= ACTIVE && (HCOUNT < 11'(H_VISIBLE)) && (VCOUNT < 11'(V_VISIBLE));
            wallQ   <= wallHit;
            paddleQ <= paddleHit;
            ballQ   <= ballHit;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RGB       <= COLOUR_BG;
            RGB_VALID <= 1'b0;
        end else begin
            RGB_VALID <= actQ;
            if (!drawQ)        RGB <= COLOUR_BG;
            else if (ballQ)    RGB <= COLOUR_BALL;
            else if (paddleQ)  RGB <= COLOUR_PADDLE;
            else if (blockHit) RGB <= blockColour(blockRow);
            else if (wallQ)    RGB <= COLOUR_WALL;
            else               RGB <= COLOUR_BG;
        end
    end

endmodule
